dm_store_buf: RTL and testbench
===============================

DM_STORE_BUF -- requirements
Module: dm_store_buf

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of store-buffer entries (power of two, 2..16).
REQ-002 The block SHALL use widths `DM_DEPTH, `DM_WIDTH and `DMBE_WIDTH from arch_def.v.
REQ-003 The block SHALL have ports:
 clk  in  1  clock; all state updates on the rising edge.
 rst  in  1  reset; synchronous, active-high.
 st_req  in  1  store request from the MEM stage; the BE/data come pre-steered by DMIn_BE.
 st_addr  in  DM_DEPTH  word address of the store.
 st_be  in  DMBE_WIDTH  byte enables of the store.
 st_data  in  DM_WIDTH  store data.
 st_ready  out  1  store accepted this cycle.
 ld_req  in  1  load request.
 ld_addr  in  DM_DEPTH  word address of the load.
 ld_ready  out  1  ld_data is valid this cycle; when 0 the pipeline stalls.
 ld_data  out  DM_WIDTH  merged word sent to DMOut_ME.
 dm_wr  out  1  DM write strobe.
 dm_be  out  DMBE_WIDTH  DM byte enables.
 dm_addr  out  DM_DEPTH  DM address, shared by reads and writes.
 dm_din  out  DM_WIDTH  DM write data.
 dm_dout  in  DM_WIDTH  combinational DM read data.
 empty  out  1  no valid entries.

Function
REQ-004 The block SHALL hold a circular FIFO of DEPTH entries {addr, be, data}, with head/tail pointers and a count of width clog2(DEPTH)+1.
REQ-005 It SHALL set st_ready = (count != DEPTH), combinationally; on st_req && st_ready it SHALL write the entry at tail and increment tail modulo DEPTH.
REQ-006 The DM port SHALL be granted to a load when ld_req && ld_ready; otherwise to drain, when count != 0.
REQ-007 A drain cycle SHALL drive dm_wr=1 and head's addr/be/data onto dm_addr/dm_be/dm_din, and SHALL increment head modulo DEPTH at the edge.
REQ-008 When neither a load nor a drain owns the port, it SHALL drive dm_wr=0, dm_be=0 and dm_addr=ld_addr.
REQ-009 When a load owns the port, it SHALL drive dm_addr=ld_addr and dm_wr=0.
REQ-010 A load SHALL have zero-cycle latency: ld_data is valid in the same cycle as ld_req when ld_ready=1.
REQ-011 When count == DEPTH and ld_req=1, drain SHALL take priority: ld_ready=0 for that cycle, and the head is written.
REQ-012 A simultaneous enqueue and drain SHALL leave count unchanged; pointer wrap-around SHALL be seamless.
REQ-013 A store accepted in cycle N SHALL be visible to loads from cycle N+1, not in cycle N.
REQ-014 When ld_req=0, ld_ready SHALL be 1 and ld_data = dm_dout, as don't-care.
REQ-015 empty SHALL be 1 exactly when count == 0.

Reset
REQ-016 When rst=1 at a clock edge, head, tail and count SHALL become 0, and all entries SHALL be discarded, including stores in mid-drain.
REQ-017 During and after reset, outputs SHALL be st_ready=1, empty=1 and dm_wr=0, with a load served directly from DM.

Configuration
REQ-018 The macro STBUF_FWD_EN SHALL control store-to-load forwarding.
REQ-019 With STBUF_FWD_EN defined: ld_data SHALL be dm_dout merged byte-wise with every valid entry whose addr == ld_addr, applied oldest-to-youngest so the youngest byte wins, and ld_ready SHALL follow REQ-011 only.
REQ-020 With STBUF_FWD_EN undefined: ld_ready SHALL be 0 while any valid entry has addr == ld_addr (drain proceeds), and ld_data SHALL be dm_dout.

Structure
REQ-021 The entry field widths and the DEPTH default SHALL be added to arch_def.v.
REQ-022 The byte-merge function SHALL be a sub-module dm_fwd_merge (inputs: base word, entry be/data; output: merged word), instantiated once per entry in a chain.
REQ-023 The FIFO storage and control SHALL stay within dm_store_buf.

Verification
REQ-024 Store then drain: DM[5]=0, st addr=5, be=1111, data=0xDEADBEEF, idle -> dm_wr=1 next cycle; DM[5]=0xDEADBEEF; empty=1.
REQ-025 Full: 4 stores with a load every cycle to addr 9 -> 5th store sees st_ready=0; the next ld_req sees ld_ready=0 for one cycle while the head drains.
REQ-026 Forwarding (FWD_EN): DM[3]=0x11223344; store addr=3 be=0001 data=0x000000AA, then store be=0010 data=0x0000BB00, then load addr 3 -> ld_data=0x1122BBAA in the same cycle.
REQ-027 No-FWD: same sequence -> ld_ready=0 until both entries drain, then ld_data=0x1122BBAA.
REQ-028 Wrap and simultaneity: 10 back-to-back stores to addrs 0..9 with no loads -> DM holds all 10 in order; count never exceeds DEPTH.
REQ-029 Reset mid-drain: 3 entries queued, rst=1 for one cycle -> empty=1, no further dm_wr, and DM changes only for the entry drained before the reset edge.

Source files
------------

// File: rtl/dm_store_buf_pkg.sv
// Shared widths, entry type and byte-merge helper for the data-memory store buffer.
// The `DM_* macros are the arch_def.v widths; defaults apply when arch_def.v is not included.
`ifndef DM_DEPTH
`define DM_DEPTH 8
`endif
`ifndef DM_WIDTH
`define DM_WIDTH 32
`endif
`ifndef DMBE_WIDTH
`define DMBE_WIDTH 4
`endif
`ifndef DM_SB_DEPTH
`define DM_SB_DEPTH 4
`endif

package dm_store_buf_pkg;

  localparam int DM_AW        = `DM_DEPTH;
  localparam int DM_DW        = `DM_WIDTH;
  localparam int DM_BW        = `DMBE_WIDTH;
  localparam int SB_DEPTH_DEF = `DM_SB_DEPTH;

  typedef logic [DM_AW-1:0] dm_addr_t;
  typedef logic [DM_BW-1:0] dm_be_t;
  typedef logic [DM_DW-1:0] dm_word_t;

  typedef struct packed {
    dm_addr_t addr;
    dm_be_t   be;
    dm_word_t data;
  } sb_entry_t;

  // Replace each byte lane of base whose enable is set with the matching lane of data.
  function automatic dm_word_t be_merge(input dm_word_t base, input dm_be_t be,
                                        input dm_word_t data);
    dm_word_t res;
    res = base;
    for (int b = 0; b < DM_BW; b++) begin
      if (be[b]) res[8*b +: 8] = data[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dm_store_buf_fwd_merge.sv
// One link of the store-to-load forwarding chain: overlays one entry's enabled bytes on a word.
module dm_fwd_merge
  import dm_store_buf_pkg::*;
(
  input  logic [DM_DW-1:0] base,
  input  logic [DM_BW-1:0] be,
  input  logic [DM_DW-1:0] data,
  output logic [DM_DW-1:0] merged
);

  always_comb begin
    // NOTE: assign a default before any conditional update so no latch is inferred.
    merged = '0;
    merged = be_merge(base, be, data);
  end

endmodule

// File: rtl/dm_store_buf.sv
// Store buffer in front of a single-port data memory: stores queue here and drain when
// loads leave the port idle. Store-to-load forwarding is enabled by defining STBUF_FWD_EN.
module dm_store_buf
  import dm_store_buf_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   st_req,
  input  logic [`DM_DEPTH-1:0]   st_addr,
  input  logic [`DMBE_WIDTH-1:0] st_be,
  input  logic [`DM_WIDTH-1:0]   st_data,
  output logic                   st_ready,
  input  logic                   ld_req,
  input  logic [`DM_DEPTH-1:0]   ld_addr,
  output logic                   ld_ready,
  output logic [`DM_WIDTH-1:0]   ld_data,
  output logic                   dm_wr,
  output logic [`DMBE_WIDTH-1:0] dm_be,
  output logic [`DM_DEPTH-1:0]   dm_addr,
  output logic [`DM_WIDTH-1:0]   dm_din,
  input  logic [`DM_WIDTH-1:0]   dm_dout,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

`ifdef STBUF_FWD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  sb_entry_t        ent [DEPTH];
  sb_entry_t        head_ent;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_eff;
  logic             full;
  logic             hit;
  logic             load_own;
  logic             drain;
  logic             enq;
  logic [DEPTH-1:0] hit_vec;
  dm_word_t         chain [DEPTH+1];

  // While rst is high the buffer already behaves as empty, so a load goes straight to DM.
  assign count_eff = rst ? '0 : count;
  assign full      = (count_eff == FULL_CNT);
  assign empty     = (count_eff == '0);
  assign st_ready  = !full;
  assign hit       = |hit_vec;

  // A full buffer always steals the port for one drain; without forwarding a pending
  // store to the load's word also stalls the load until it reaches DM.
  assign ld_ready  = !ld_req || !(full || (!FWD_ON && hit));
  assign load_own  = ld_req && ld_ready;
  assign drain     = !load_own && !empty;
  assign enq       = st_req && st_ready && !rst;

  assign head_ent  = ent[head];
  assign dm_wr     = drain;
  assign dm_addr   = drain ? head_ent.addr : ld_addr;
  assign dm_be     = drain ? head_ent.be   : '0;
  assign dm_din    = drain ? head_ent.data : '0;

  // Walk entries by age from head so younger stores overwrite older bytes.
  assign chain[0]  = dm_dout;
  assign ld_data   = chain[DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_age
    logic [PW-1:0]    idx;
    logic             live;
    logic             match;
    logic [DM_BW-1:0] fwd_be;

    assign idx        = head + PW'(g);
    assign live       = (CW'(g) < count_eff);
    assign match      = live && (ent[idx].addr == ld_addr);
    assign hit_vec[g] = match;
    assign fwd_be     = ent[idx].be & {DM_BW{match && FWD_ON}};

    dm_fwd_merge u_merge (
      .base   (chain[g]),
      .be     (fwd_be),
      .data   (ent[idx].data),
      .merged (chain[g+1])
    );
  end

  // NOTE: entry storage has no reset; an entry is meaningful only while count covers it.
  always_ff @(posedge clk) begin
    if (enq) begin
      ent[tail] <= '{addr: st_addr, be: st_be, data: st_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq)   tail <= tail + 1'b1;
      if (drain) head <= head + 1'b1;
      case ({enq, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_store_buf.sv
// Self-checking bench for dm_store_buf: directed scenarios plus random traffic against a
// queue-based reference model and a behavioural data memory.
module tb_dm_store_buf;
  import dm_store_buf_pkg::*;

  localparam int MEMW = 1 << DM_AW;

  logic     clk;
  logic     rst;
  logic     st_req;
  dm_addr_t st_addr;
  dm_be_t   st_be;
  dm_word_t st_data;
  logic     st_ready;
  logic     ld_req;
  dm_addr_t ld_addr;
  logic     ld_ready;
  dm_word_t ld_data;
  logic     dm_wr;
  dm_be_t   dm_be;
  dm_addr_t dm_addr;
  dm_word_t dm_din;
  dm_word_t dm_dout;
  logic     empty;

  dm_word_t  dm_mem  [MEMW];
  dm_word_t  ref_mem [MEMW];
  sb_entry_t mq [$];

  int checks = 0;
  int errors = 0;

  logic     o_st_ready, o_ld_ready, o_dm_wr, o_empty;
  dm_word_t o_ld_data;
  dm_addr_t o_dm_addr;

  dm_store_buf #(.DEPTH(SB_DEPTH_DEF)) dut (
    .clk      (clk),
    .rst      (rst),
    .st_req   (st_req),
    .st_addr  (st_addr),
    .st_be    (st_be),
    .st_data  (st_data),
    .st_ready (st_ready),
    .ld_req   (ld_req),
    .ld_addr  (ld_addr),
    .ld_ready (ld_ready),
    .ld_data  (ld_data),
    .dm_wr    (dm_wr),
    .dm_be    (dm_be),
    .dm_addr  (dm_addr),
    .dm_din   (dm_din),
    .dm_dout  (dm_dout),
    .empty    (empty)
  );

  assign dm_dout = dm_mem[dm_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Byte-lane write expressed as a mask, the way a byte-enabled RAM behaves.
  function automatic dm_word_t lane_write(input dm_word_t old, input dm_be_t be,
                                          input dm_word_t val);
    dm_word_t mask;
    for (int b = 0; b < DM_BW; b++) mask[8*b +: 8] = {8{be[b]}};
    return (old & ~mask) | (val & mask);
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, then advance both.
  task automatic step(input logic r, input logic sq, input dm_addr_t sa, input dm_be_t sb,
                      input dm_word_t sd, input logic lq, input dm_addr_t la);
    int       n;
    logic     e_full, e_hit, e_ldr, e_drain;
    dm_word_t e_ld;
    logic     w;
    dm_addr_t wa;
    dm_be_t   wb;
    dm_word_t wd;

    @(negedge clk);
    rst = r; st_req = sq; st_addr = sa; st_be = sb; st_data = sd;
    ld_req = lq; ld_addr = la;
    #1;
    n      = r ? 0 : mq.size();
    e_full = (n == SB_DEPTH_DEF);
    e_hit  = 1'b0;
    for (int i = 0; i < n; i++) if (mq[i].addr == la) e_hit = 1'b1;
`ifdef STBUF_FWD_EN
    e_ldr = !lq || !e_full;
`else
    e_ldr = !lq || !(e_full || e_hit);
`endif
    e_drain = !(lq && e_ldr) && (n > 0);

    check("st_ready", 32'(st_ready), 32'(!e_full));
    check("empty",    32'(empty),    32'(n == 0));
    check("ld_ready", 32'(ld_ready), 32'(e_ldr));
    check("dm_wr",    32'(dm_wr),    32'(e_drain));
    if (e_drain) begin
      check("drain_addr", 32'(dm_addr), 32'(mq[0].addr));
      check("drain_be",   32'(dm_be),   32'(mq[0].be));
      check("drain_din",  dm_din,       mq[0].data);
    end else begin
      check("idle_addr", 32'(dm_addr), 32'(la));
      check("idle_be",   32'(dm_be),   32'(0));
    end
    if (lq && e_ldr) begin
      e_ld = ref_mem[la];
`ifdef STBUF_FWD_EN
      for (int i = 0; i < n; i++)
        if (mq[i].addr == la) e_ld = lane_write(e_ld, mq[i].be, mq[i].data);
`endif
      check("ld_data", ld_data, e_ld);
    end

    o_st_ready = st_ready; o_ld_ready = ld_ready; o_ld_data = ld_data;
    o_dm_wr = dm_wr; o_empty = empty; o_dm_addr = dm_addr;
    w = dm_wr; wa = dm_addr; wb = dm_be; wd = dm_din;

    @(posedge clk);
    if (w) dm_mem[wa] = lane_write(dm_mem[wa], wb, wd);
    if (r) begin
      mq.delete();
    end else begin
      if (e_drain) begin
        ref_mem[mq[0].addr] = lane_write(ref_mem[mq[0].addr], mq[0].be, mq[0].data);
        void'(mq.pop_front());
      end
      if (sq && !e_full) mq.push_back('{addr: sa, be: sb, data: sd});
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic drain_all(input string tag);
    for (int k = 0; k < 4 * SB_DEPTH_DEF && !(o_empty === 1'b1 && mq.size() == 0); k++) idle();
    check(tag, 32'(o_empty), 32'(1));
  endtask

  initial begin
    rst = 1'b1; st_req = 1'b0; st_addr = '0; st_be = '0; st_data = '0;
    ld_req = 1'b0; ld_addr = '0;
    for (int a = 0; a < MEMW; a++) begin
      dm_mem[a]  = 32'h0A0B_0000 + 32'(a);
      ref_mem[a] = 32'h0A0B_0000 + 32'(a);
    end
    dm_mem[5] = '0;            ref_mem[5] = '0;
    dm_mem[3] = 32'h1122_3344; ref_mem[3] = 32'h1122_3344;

    // Reset state, with a load served from DM while reset is held.
    step(1'b1, 1'b1, 8'd7, 4'hF, 32'h1234_5678, 1'b1, 8'd12);
    check("rst_st_ready", 32'(o_st_ready), 32'(1));
    check("rst_ld_data",  o_ld_data, 32'h0A0B_000C);
    step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
    check("rst_empty", 32'(o_empty), 32'(1));
    check("rst_dm_wr", 32'(o_dm_wr), 32'(0));

    // Store then drain on the next idle cycle.
    step(1'b0, 1'b1, 8'd5, 4'hF, 32'hDEAD_BEEF, 1'b0, '0);
    check("s1_no_wr", 32'(o_dm_wr), 32'(0));
    idle();
    check("s1_wr",   32'(o_dm_wr),   32'(1));
    check("s1_addr", 32'(o_dm_addr), 32'(5));
    idle();
    check("s1_mem",   dm_mem[5], 32'hDEAD_BEEF);
    check("s1_empty", 32'(o_empty), 32'(1));

    // Fill with a load every cycle; the fifth store and the next load both stall.
    for (int i = 0; i < SB_DEPTH_DEF; i++) begin
      step(1'b0, 1'b1, 8'(20 + i), 4'hF, 32'hF000_0000 + 32'(i), 1'b1, 8'd9);
      check("fill_st_ready", 32'(o_st_ready), 32'(1));
    end
    step(1'b0, 1'b1, 8'd30, 4'hF, 32'hF000_00FF, 1'b1, 8'd9);
    check("full_st_ready", 32'(o_st_ready), 32'(0));
    check("full_ld_ready", 32'(o_ld_ready), 32'(0));
    check("full_dm_wr",    32'(o_dm_wr),    32'(1));
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 8'd9);
    check("after_full_ld_ready", 32'(o_ld_ready), 32'(1));
    check("after_full_ld_data",  o_ld_data, 32'h0A0B_0009);
    drain_all("full_drained");
    check("full_mem_head", dm_mem[20], 32'hF000_0000);

    // Two partial stores to one word, then a load of that word.
    step(1'b0, 1'b1, 8'd3, 4'b0001, 32'h0000_00AA, 1'b1, 8'd9);
    step(1'b0, 1'b1, 8'd3, 4'b0010, 32'h0000_BB00, 1'b1, 8'd9);
`ifdef STBUF_FWD_EN
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 8'd3);
    check("fwd_ld_ready", 32'(o_ld_ready), 32'(1));
    check("fwd_ld_data",  o_ld_data, 32'h1122_BBAA);
`else
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 8'd3);
    check("nofwd_stall", 32'(o_ld_ready), 32'(0));
    for (int k = 0; k < 8 && o_ld_ready !== 1'b1; k++) step(1'b0, 1'b0, '0, '0, '0, 1'b1, 8'd3);
    check("nofwd_ld_ready", 32'(o_ld_ready), 32'(1));
    check("nofwd_ld_data",  o_ld_data, 32'h1122_BBAA);
`endif
    drain_all("fwd_drained");
    check("fwd_mem", dm_mem[3], 32'h1122_BBAA);

    // Ten back-to-back stores: enqueue and drain overlap, pointers wrap.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 8'(i), 4'hF, 32'h5A00_0000 + 32'(i), 1'b0, '0);
      check("b2b_st_ready", 32'(o_st_ready), 32'(1));
    end
    drain_all("b2b_drained");
    for (int i = 0; i < 10; i++) check("b2b_mem", dm_mem[i], 32'h5A00_0000 + 32'(i));

    // Reset while entries are queued: only the already-drained entry reaches DM.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'(40 + i), 4'hF, 32'hC0DE_0000 + 32'(i), 1'b1, 8'd9);
    idle();
    check("mid_drain_wr", 32'(o_dm_wr), 32'(1));
    step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
    check("mid_rst_wr", 32'(o_dm_wr), 32'(0));
    for (int k = 0; k < 3; k++) begin
      idle();
      check("post_rst_wr",    32'(o_dm_wr), 32'(0));
      check("post_rst_empty", 32'(o_empty), 32'(1));
    end
    check("rst_mem40", dm_mem[40], 32'hC0DE_0000);
    check("rst_mem41", dm_mem[41], 32'h0A0B_0029);
    check("rst_mem42", dm_mem[42], 32'h0A0B_002A);

    // Random traffic on a few hot words so hits, merges and full stalls are common.
    for (int c = 0; c < 600; c++) begin
      step($urandom_range(0, 59) == 0,
           $urandom_range(0, 2) != 0,
           8'(48 + $urandom_range(0, 3)),
           4'($urandom_range(0, 15)),
           32'($urandom),
           $urandom_range(0, 1) == 1,
           8'(48 + $urandom_range(0, 4)));
    end
    drain_all("rand_drained");
    for (int a = 0; a < 64; a++) check("final_mem", dm_mem[a], ref_mem[a]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
